clock_set_ctrl: RTL and testbench

//   Time-set controller for the clock design. Takes two debounced button levels (mode, inc)
//   and a 1 Hz tick. Sequences a RUN / SET_HOUR / SET_MIN mode FSM and owns the hour/min/sec

---
 rtl/clock_set_ctrl_if.sv | 21 ++
 rtl/clock_set_ctrl.sv | 151 +++++++++++++++
 tb/tb_clock_set_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/clock_set_ctrl_if.sv
// Button/tick inputs and time/mode outputs of the clock time-set controller.
// master drives buttons and tick; slave (the controller) drives mode and time.
interface clock_set_ctrl_if;
    logic       btn_mode;
    logic       btn_inc;
    logic       tick_1hz;
    logic [1:0] mode;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;

    modport master (
        output btn_mode, btn_inc, tick_1hz,
        input  mode, hour, min, sec
    );

    modport slave (
        input  btn_mode, btn_inc, tick_1hz,
        output mode, hour, min, sec
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// Clock time-set controller: RUN/SET_HOUR/SET_MIN FSM owning hour/min/sec; AUTO_REPEAT_EN adds inc hold-repeat.
// Latency: a button edge or tick shows on the registered outputs one cycle later.
// Backpressure: none; levels and tick pulses are consumed every cycle.
module clock_set_ctrl #(
    parameter int HOLD_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000,
    parameter int CNT_W         = 25
) (
    input  logic              cclk,
    input  logic              clr,
    clock_set_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10,
        BAD      = 2'b11
    } state_t;

    if ($clog2(HOLD_CYCLES + 1) > CNT_W || $clog2(REPEAT_CYCLES + 1) > CNT_W) begin : g_cnt_w_check
        $error("CNT_W too narrow for HOLD_CYCLES/REPEAT_CYCLES");
    end

    state_t     state_q, state_d;
    logic [4:0] hour_q, hour_d;
    logic [5:0] min_q, min_d;
    logic [5:0] sec_q, sec_d;
    logic       mode_btn_q, mode_btn_d;
    logic       inc_btn_q, inc_btn_d;
    logic       mode_edge, inc_edge, inc_evt;

`ifdef AUTO_REPEAT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rep_q, rep_d;
    logic             rpt_fire;
`endif

    // Edge regs follow the buttons even during reset, so a level held through reset is not an edge.
    always_ff @(posedge cclk) begin
        if (clr) begin
            state_q    <= RUN;
            hour_q     <= '0;
            min_q      <= '0;
            sec_q      <= '0;
            mode_btn_q <= mode_btn_d;
            inc_btn_q  <= inc_btn_d;
`ifdef AUTO_REPEAT_EN
            cnt_q      <= '0;
            rep_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            mode_btn_q <= mode_btn_d;
            inc_btn_q  <= inc_btn_d;
`ifdef AUTO_REPEAT_EN
            cnt_q      <= cnt_d;
            rep_q      <= rep_d;
`endif
        end
    end

    always_comb begin
        mode_btn_d = bus.btn_mode;
        inc_btn_d  = bus.btn_inc;
        mode_edge  = bus.btn_mode & ~mode_btn_q;
        inc_edge   = bus.btn_inc & ~inc_btn_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (mode_edge) state_d = SET_HOUR;
            SET_HOUR: if (mode_edge) state_d = SET_MIN;
            SET_MIN:  if (mode_edge) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

`ifdef AUTO_REPEAT_EN
    // cnt_q == 0 means disarmed; only an inc edge in a SET state arms it.
    always_comb begin
        cnt_d    = '0;
        rep_d    = 1'b0;
        rpt_fire = 1'b0;
        if ((state_q == SET_HOUR || state_q == SET_MIN) && !mode_edge && bus.btn_inc) begin
            if (inc_edge) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != '0) begin
                rpt_fire = rep_q ? (cnt_q == CNT_W'(REPEAT_CYCLES))
                                 : (cnt_q == CNT_W'(HOLD_CYCLES));
                if (rpt_fire) begin
                    cnt_d = CNT_W'(1);
                    rep_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    rep_d = rep_q;
                end
            end
        end
        inc_evt = inc_edge | rpt_fire;
    end
`else
    always_comb inc_evt = inc_edge;
`endif

    always_comb begin
        hour_d = hour_q;
        min_d  = min_q;
        sec_d  = sec_q;
        case (state_q)
            RUN: begin
                if (bus.tick_1hz) begin
                    if (sec_q == 6'd59) begin
                        sec_d = '0;
                        if (min_q == 6'd59) begin
                            min_d  = '0;
                            hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                        end else begin
                            min_d = min_q + 6'd1;
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end
            end
            SET_HOUR: begin
                if (inc_evt && !mode_edge)
                    hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
            end
            SET_MIN: begin
                if (mode_edge)
                    sec_d = '0;
                else if (inc_evt)
                    min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.mode = state_q;
        bus.hour = hour_q;
        bus.min  = min_q;
        bus.sec  = sec_q;
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed-vector bench for clock_set_ctrl with HOLD_CYCLES=8, REPEAT_CYCLES=4, CNT_W=4.
module tb_clock_set_ctrl;

`ifdef AUTO_REPEAT_EN
    localparam int AR = 1;
`else
    localparam int AR = 0;
`endif

    logic cclk;
    logic clr;
    int   n_vec;
    int   n_miss;

    clock_set_ctrl_if bus ();

    clock_set_ctrl #(
        .HOLD_CYCLES   (8),
        .REPEAT_CYCLES (4),
        .CNT_W         (4)
    ) dut (
        .cclk (cclk),
        .clr  (clr),
        .bus  (bus)
    );

    initial cclk = 1'b0;
    always #5 cclk = ~cclk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, "_hour"}, int'(bus.hour), h);
        check({tag, "_min"},  int'(bus.min),  m);
        check({tag, "_sec"},  int'(bus.sec),  s);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge cclk);
    endtask

    task automatic tick_n(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            bus.tick_1hz = 1'b1;
            @(negedge cclk);
            bus.tick_1hz = 1'b0;
            repeat (gap - 1) @(negedge cclk);
        end
    endtask

    task automatic pulse_mode();
        bus.btn_mode = 1'b1;
        @(negedge cclk);
        bus.btn_mode = 1'b0;
        @(negedge cclk);
    endtask

    task automatic pulse_inc(input int n);
        for (int i = 0; i < n; i++) begin
            bus.btn_inc = 1'b1;
            @(negedge cclk);
            bus.btn_inc = 1'b0;
            @(negedge cclk);
        end
    endtask

    initial begin
        n_vec        = 0;
        n_miss       = 0;
        clr          = 1'b1;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.tick_1hz = 1'b0;
        cyc(2);
        check("rst_mode", int'(bus.mode), 0);
        check_time("rst", 0, 0, 0);
        clr = 1'b0;
        cyc(1);

        // RUN counting and carries
        tick_n(59, 3);
        check_time("t1_59s", 0, 0, 59);
        tick_n(1, 3);
        check_time("t1_1m", 0, 1, 0);
        tick_n(3540, 3);
        check_time("t1_1h", 1, 0, 0);

        // preset 23:59:00 then wrap through midnight
        pulse_mode();
        check("t1_mode_sh", int'(bus.mode), 1);
        pulse_inc(22);
        check("t1_h23", int'(bus.hour), 23);
        pulse_mode();
        pulse_inc(59);
        pulse_mode();
        check("t1_mode_run", int'(bus.mode), 0);
        check_time("t1_2359", 23, 59, 0);
        tick_n(59, 3);
        check_time("t1_235959", 23, 59, 59);
        tick_n(1, 3);
        check_time("t1_wrap", 0, 0, 0);
        tick_n(37, 1);
        check_time("t1_37s", 0, 0, 37);

        // SET_HOUR: 25 increments, ticks ignored
        pulse_mode();
        for (int i = 0; i < 25; i++) begin
            pulse_inc(1);
            if (i % 5 == 0) tick_n(1, 1);
        end
        check("t2_mode", int'(bus.mode), 1);
        check_time("t2", 1, 0, 37);

        // SET_MIN: 61 increments, no carry, exit clears sec
        pulse_mode();
        check("t3_mode_sm", int'(bus.mode), 2);
        pulse_inc(61);
        check_time("t3_set", 1, 1, 37);
        pulse_mode();
        check("t3_mode_run", int'(bus.mode), 0);
        check_time("t3_exit", 1, 1, 0);

        // simultaneous events
        tick_n(5, 1);
        check("t4_sec5", int'(bus.sec), 5);
        bus.btn_mode = 1'b1; bus.tick_1hz = 1'b1;
        @(negedge cclk);
        bus.btn_mode = 1'b0; bus.tick_1hz = 1'b0;
        @(negedge cclk);
        check("t4_run2sh_mode", int'(bus.mode), 1);
        check("t4_run2sh_sec", int'(bus.sec), 6);
        bus.btn_mode = 1'b1; bus.btn_inc = 1'b1;
        @(negedge cclk);
        bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;
        @(negedge cclk);
        check("t4_mode_inc_mode", int'(bus.mode), 2);
        check_time("t4_mode_inc", 1, 1, 6);
        bus.btn_mode = 1'b1; bus.tick_1hz = 1'b1;
        @(negedge cclk);
        bus.btn_mode = 1'b0; bus.tick_1hz = 1'b0;
        @(negedge cclk);
        check("t4_sm2run_mode", int'(bus.mode), 0);
        check_time("t4_sm2run", 1, 1, 0);
        pulse_inc(1);
        check_time("t4_run_inc", 1, 1, 0);

        // held inc in SET_MIN
        pulse_mode();
        pulse_mode();
        check("t5_mode", int'(bus.mode), 2);
        pulse_inc(59);
        check("t5_min0", int'(bus.min), 0);
        bus.btn_inc = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge cclk);
            if (i == 1)  check("t5_edge", int'(bus.min), 1);
            if (i == 8)  check("t5_pre_hold", int'(bus.min), 1);
            if (i == 9)  check("t5_hold", int'(bus.min), AR ? 2 : 1);
            if (i == 13) check("t5_rep1", int'(bus.min), AR ? 3 : 1);
        end
        bus.btn_inc = 1'b0;
        cyc(1);
        check("t5_final", int'(bus.min), AR ? 4 : 1);

        // reset mid-operation with inc held
        pulse_mode();
        pulse_mode();
        check("t6_mode_sh", int'(bus.mode), 1);
        bus.btn_inc = 1'b1;
        cyc(1);
        check("t6_hour_inc", int'(bus.hour), 2);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        check("t6_rst_mode", int'(bus.mode), 0);
        check_time("t6_rst", 0, 0, 0);
        cyc(12);
        bus.btn_inc = 1'b0;
        cyc(2);
        check("t6_after_mode", int'(bus.mode), 0);
        check_time("t6_after", 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
